uart_rx: RTL and testbench

UART serial receiver that consumes the 16x-oversampling `tick` strobe produced by the baud rate generator. It resynchronises the asynchronous `rx` line, detects and validates the start bit, and samples each data bit at mid-bit. It then checks the stop bit and presents the assembled byte with a one-cycle done strobe. It sits between the board pin and the UART interface/FIFO logic, in the opposite data direction from the transmitter.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame/oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } rx_state_e;

  localparam int unsigned DefDbit        = 8;
  localparam int unsigned DefSbTick      = 16;
  localparam int unsigned OversampleRate = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start validation, mid-bit data sampling, stop-bit check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DefDbit,
  parameter int unsigned SB_TICK = DefSbTick
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rx,
  input  logic            tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam logic [4:0] SHalf = 5'(OversampleRate / 2 - 1);
  localparam logic [4:0] SBit  = 5'(OversampleRate - 1);
  localparam logic [4:0] SStop = 5'(SB_TICK - 1);
  localparam logic [2:0] NLast = 3'(DBIT - 1);

  logic            rx_s;
  rx_state_e       state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i(clock),
    .rst_i(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == SHalf) begin
            // Line still low at mid start bit: genuine start, else a glitch.
            state_d = rx_s ? StIdle : StData;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == SBit) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == NLast) begin
              state_d = StStop;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (s_q == SStop) begin
            state_d = StIdle;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level expectation queue plus directed literal checks.
module tb_uart_rx;

  typedef struct {
    logic [7:0]  data;
    logic        ferr;
    int unsigned t0;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       tick  = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int unsigned tick_cnt = 0;
  int unsigned done_cnt = 0;
  exp_t        exp_q[$];
  logic [7:0]  exp_dout = 8'h00;
  logic        exp_ferr = 1'b0;

  always #5 clock = ~clock;

  uart_rx dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .tick        (tick),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One tick every 4 clocks, changed 2 time units after the edge.
  task automatic tick_gen();
    int ph = 0;
    forever begin
      @(posedge clock);
      #2;
      ph   = (ph + 1) % 4;
      tick = (ph == 0);
      if (ph == 0) tick_cnt++;
    end
  endtask

  // Every frame that completes must match the oldest outstanding one; between pulses outputs hold.
  task automatic compare_loop();
    exp_t        e;
    int unsigned lat;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        exp_dout = 8'h00;
        exp_ferr = 1'b0;
      end else if (rx_done_tick) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_done: got pulse with dout=0x%0h, expected no pulse", dout);
        end else begin
          e = exp_q.pop_front();
          chk("done_dout", 32'(dout), 32'(e.data));
          chk("done_ferr", 32'(frame_err), 32'(e.ferr));
          lat = tick_cnt - e.t0;
          n_tests++;
          if (lat < 152 || lat > 153) begin
            n_fail++;
            $display("FAIL latency: got %0d ticks, expected 152..153", lat);
          end
          exp_dout = e.data;
          exp_ferr = e.ferr;
        end
      end else begin
        chk("hold_dout", 32'(dout), 32'(exp_dout));
        chk("hold_ferr", 32'(frame_err), 32'(exp_ferr));
      end
    end
  endtask

  // Drives one 8N1 frame; abort_bit >= 0 pulses reset at that data bit and idles the line.
  task automatic send_frame(input logic [7:0] data, input int period, input bit stop_low,
                            input int abort_bit);
    exp_t e;
    rx = 1'b0;
    if (abort_bit < 0) begin
      e.data = data;
      e.ferr = stop_low;
      e.t0   = tick_cnt;
      exp_q.push_back(e);
    end
    hold(period);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        reset = 1'b1;
        rx    = 1'b1;
        hold(1);
        reset = 1'b0;
        hold(12 * 64);
        return;
      end
      rx = data[i];
      hold(period);
    end
    if (stop_low) begin
      // Low through the stop sample point only, then idle long enough to settle.
      rx = 1'b0;
      hold(48);
      rx = 1'b1;
      hold(16 + 64);
    end else begin
      rx = 1'b1;
      hold(period);
    end
  endtask

  task automatic stimulus();
    int unsigned d0;
    hold(3);
    chk("reset_dout", 32'(dout), 32'h00);
    chk("reset_done", 32'(rx_done_tick), 32'h0);
    chk("reset_ferr", 32'(frame_err), 32'h0);
    reset = 1'b0;
    hold(64);

    d0 = done_cnt;
    send_frame(8'hA5, 64, 1'b0, -1);
    chk("a5_pulses", done_cnt - d0, 32'd1);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_ferr", 32'(frame_err), 32'h0);
    hold(64);

    d0 = done_cnt;
    rx = 1'b0;
    hold(12);
    rx = 1'b1;
    hold(256);
    chk("glitch_pulses", done_cnt - d0, 32'd0);
    chk("glitch_dout", 32'(dout), 32'hA5);

    send_frame(8'h3C, 64, 1'b1, -1);
    chk("3c_dout", 32'(dout), 32'h3C);
    chk("3c_ferr", 32'(frame_err), 32'h1);
    send_frame(8'h81, 64, 1'b0, -1);
    chk("81_dout", 32'(dout), 32'h81);
    chk("81_ferr", 32'(frame_err), 32'h0);
    hold(64);

    d0 = done_cnt;
    send_frame(8'h00, 64, 1'b0, -1);
    send_frame(8'hFF, 64, 1'b0, -1);
    send_frame(8'h55, 64, 1'b0, -1);
    chk("b2b_pulses", done_cnt - d0, 32'd3);
    chk("b2b_dout", 32'(dout), 32'h55);
    hold(64);

    d0 = done_cnt;
    send_frame(8'h99, 64, 1'b0, 4);
    chk("rst_pulses", done_cnt - d0, 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    send_frame(8'h7E, 64, 1'b0, -1);
    chk("7e_dout", 32'(dout), 32'h7E);
    hold(64);

    send_frame(8'hC3, 62, 1'b0, -1);
    chk("c3_fast_dout", 32'(dout), 32'hC3);
    hold(64);
    send_frame(8'hC3, 66, 1'b0, -1);
    chk("c3_slow_dout", 32'(dout), 32'hC3);
    hold(64);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      bit         sl;
      int         per;
      b   = 8'($urandom_range(0, 255));
      sl  = ($urandom_range(0, 7) == 0);
      per = sl ? 64 : 62 + 2 * int'($urandom_range(0, 2));
      send_frame(b, per, sl, -1);
      if ($urandom_range(0, 3) != 0) hold(int'($urandom_range(1, 100)));
    end

    hold(300);
    chk("frames_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      tick_gen();
      compare_loop();
      stimulus();
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
